// File: rtl/truth_table_sequencer_if.sv
// Control/status and gate-facing signals of the truth-table sequencer.
// valid/ready style does not apply: start/abort are level-sampled, done is a one-cycle pulse.
interface truth_table_sequencer_if #(
   parameter int N_IN = 3
) ();
   logic                 start;
   logic                 abort;
   logic [N_IN-1:0]      dut_in;
   logic                 dut_out;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [2**N_IN-1:0]   table_q;
   logic [N_IN:0]        err_cnt;
   logic [N_IN-1:0]      fail_idx;
   logic [1:0]           state_dbg;

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, pass, table_q, err_cnt, fail_idx, state_dbg
   );

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, pass, table_q, err_cnt, fail_idx, state_dbg
   );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks a combinational gate through all input vectors, captures its truth table and
// compares it against EXPECTED, reporting pass, mismatch count and first failing index.
module truth_table_sequencer #(
   parameter int                  N_IN     = 3,
   parameter int                  SETTLE   = 2,
   parameter logic [2**N_IN-1:0]  EXPECTED = 8'h7F
) (
   input  logic                    clk,
   input  logic                    rst_n,
   truth_table_sequencer_if.slave  bus
);
   localparam int NV = 2**N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [N_IN-1:0]   r_vec;
   logic [CW-1:0]     r_cnt;
   logic [NV-1:0]     r_table;
   logic [N_IN:0]     r_err;
   logic [N_IN-1:0]   r_fail;
   logic              r_pass;

   logic              w_mismatch;
   logic [N_IN:0]     w_err_inc;
   logic              w_last;
   logic              w_drive;

   assign w_mismatch = (bus.dut_out != EXPECTED[r_vec]);
   assign w_err_inc  = r_err + (N_IN+1)'(w_mismatch);
   assign w_last     = (r_vec == N_IN'(NV-1));
   assign w_drive    = (r_state == S_SETTLE) || (r_state == S_SAMPLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // abort overrides every transition, including a start seen in the same cycle
   always_comb begin
      w_next = r_state;
      if (bus.abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (bus.start) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == '0) w_next = S_SAMPLE;
            S_SAMPLE: w_next = w_last ? S_DONE : S_SETTLE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec   <= '0;
         r_cnt   <= '0;
         r_table <= '0;
         r_err   <= '0;
         r_fail  <= '0;
         r_pass  <= 1'b0;
      end else if (!bus.abort) begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_vec   <= '0;
                  r_cnt   <= CW'(SETTLE-1);
                  r_table <= '0;
                  r_err   <= '0;
                  r_fail  <= '0;
                  r_pass  <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end
            S_SAMPLE: begin
               r_table[r_vec] <= bus.dut_out;
               if (w_mismatch) begin
                  r_err <= w_err_inc;
                  if (r_err == '0) r_fail <= r_vec;
               end
               // pass is registered here so it is already valid in the done cycle
               if (w_last) begin
                  r_pass <= (w_err_inc == '0);
               end else begin
                  r_vec <= r_vec + N_IN'(1);
                  r_cnt <= CW'(SETTLE-1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.dut_in    = w_drive ? r_vec : '0;
   assign bus.busy      = w_drive;
   assign bus.done      = (r_state == S_DONE);
   assign bus.pass      = r_pass;
   assign bus.table_q   = r_table;
   assign bus.err_cnt   = r_err;
   assign bus.fail_idx  = r_fail;
   assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: gate models drive dut_out, expected vectors are queued
// at start and popped each busy cycle, final results checked at the done pulse.
module tb_truth_table_sequencer;
   localparam int N_IN = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         mode = 0;
   logic [7:0] rand_tab = 8'h00;
   logic [N_IN-1:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   truth_table_sequencer_if #(.N_IN(N_IN)) bus ();

   truth_table_sequencer #(.N_IN(N_IN), .SETTLE(2), .EXPECTED(8'h7F)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // gate under test: 0 = NAND3, 1 = stuck-at-0, 2 = NAND(a,b), 3 = random table
   always_comb begin
      case (mode)
         0:       bus.dut_out = ~(bus.dut_in[2] & bus.dut_in[1] & bus.dut_in[0]);
         1:       bus.dut_out = 1'b0;
         2:       bus.dut_out = ~(bus.dut_in[2] & bus.dut_in[1]);
         default: bus.dut_out = rand_tab[bus.dut_in];
      endcase
   end

   task automatic start_pulse();
      @(negedge clk);
      bus.start = 1'b1;
   endtask

   // entered at a negedge with start already high; the following posedge samples it
   task automatic monitor_run(input bit keep_start, input logic [7:0] etab,
                              input logic [3:0] eerr, input logic [2:0] efail,
                              input logic epass, input string nm);
      int k;
      bit seen;
      logic [N_IN-1:0] e;
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(3'(i / 3));
      @(posedge clk);
      #1;
      if (!keep_start) bus.start = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            n_cmp++;
            if (bus.busy && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (bus.dut_in !== e) begin
                  n_err++;
                  $display("FAIL %s vec cycle %0d: dut_in=%0d expected %0d", nm, k, bus.dut_in, e);
               end
            end else begin
               n_err++;
               $display("FAIL %s seq cycle %0d: busy=%b with %0d vectors pending", nm, k, bus.busy, exp_q.size());
            end
            k++;
         end
      end
      n_cmp++;
      if (!seen || k != 24) begin
         n_err++;
         $display("FAIL %s latency: done seen=%0d after %0d edges, expected 24", nm, seen, k);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s leftover: %0d vectors not driven, expected 0", nm, exp_q.size());
      end
      n_cmp++;
      if (bus.table_q !== etab) begin
         n_err++;
         $display("FAIL %s table_q: got %h expected %h", nm, bus.table_q, etab);
      end
      n_cmp++;
      if (bus.err_cnt !== eerr) begin
         n_err++;
         $display("FAIL %s err_cnt: got %0d expected %0d", nm, bus.err_cnt, eerr);
      end
      n_cmp++;
      if (bus.fail_idx !== efail) begin
         n_err++;
         $display("FAIL %s fail_idx: got %0d expected %0d", nm, bus.fail_idx, efail);
      end
      n_cmp++;
      if (bus.pass !== epass) begin
         n_err++;
         $display("FAIL %s pass: got %b expected %b", nm, bus.pass, epass);
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.dut_in !== 3'd0) begin
         n_err++;
         $display("FAIL %s done_cycle: busy=%b dut_in=%0d expected 0/0", nm, bus.busy, bus.dut_in);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      mode = 0;
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
         n_err++;
         $display("FAIL reset flags: busy/done/pass=%b expected 000", {bus.busy, bus.done, bus.pass});
      end
      n_cmp++;
      if (bus.table_q !== 8'h00 || bus.err_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL reset regs: table_q=%h err_cnt=%0d expected 00/0", bus.table_q, bus.err_cnt);
      end
      n_cmp++;
      if (bus.fail_idx !== 3'd0 || bus.dut_in !== 3'd0) begin
         n_err++;
         $display("FAIL reset idx: fail_idx=%0d dut_in=%0d expected 0/0", bus.fail_idx, bus.dut_in);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nand();
      mode = 0;
      start_pulse();
      monitor_run(1'b0, 8'h7F, 4'd0, 3'd0, 1'b1, "nand");
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.pass !== 1'b1 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL nand hold: pass=%b done=%b expected 1/0", bus.pass, bus.done);
      end
   endtask

   task automatic test_mismatch();
      mode = 1;
      start_pulse();
      monitor_run(1'b0, 8'h00, 4'd7, 3'd0, 1'b0, "stuck0");
      mode = 2;
      start_pulse();
      monitor_run(1'b0, 8'h3F, 4'd1, 3'd6, 1'b0, "nand_ab");
   endtask

   task automatic test_random();
      logic [7:0] x;
      logic [3:0] eerr;
      logic [2:0] efail;
      mode = 3;
      for (int r = 0; r < 3; r++) begin
         rand_tab = 8'($urandom_range(0, 255));
         x = rand_tab ^ 8'h7F;
         eerr = 4'($countones(x));
         efail = 3'd0;
         for (int i = 7; i >= 0; i--) if (x[i]) efail = 3'(i);
         start_pulse();
         monitor_run(1'b0, rand_tab, eerr, efail, (x == 8'h00), "random");
      end
   endtask

   task automatic test_abort();
      bit saw_done;
      mode = 0;
      start_pulse();
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin
         n_err++;
         $display("FAIL abort flags: busy=%b done=%b pass=%b expected 0/0/0", bus.busy, bus.done, bus.pass);
      end
      n_cmp++;
      if (bus.table_q !== 8'h07 || bus.err_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL abort partial: table_q=%h err_cnt=%0d expected 07/0", bus.table_q, bus.err_cnt);
      end
      saw_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done) begin
         n_err++;
         $display("FAIL abort idle: activity=1 after abort expected 0");
      end
      start_pulse();
      monitor_run(1'b0, 8'h7F, 4'd0, 3'd0, 1'b1, "after_abort");
   endtask

   task automatic test_back_to_back();
      mode = 0;
      start_pulse();
      monitor_run(1'b1, 8'h7F, 4'd0, 3'd0, 1'b1, "held_start1");
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.state_dbg !== 2'd0) begin
         n_err++;
         $display("FAIL b2b idle: busy=%b state=%0d expected 0/0", bus.busy, bus.state_dbg);
      end
      monitor_run(1'b0, 8'h7F, 4'd0, 3'd0, 1'b1, "held_start2");
   endtask

   task automatic test_reset_midrun();
      mode = 1;
      start_pulse();
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.err_cnt !== 4'd4) begin
         n_err++;
         $display("FAIL midrun pre: busy=%b err_cnt=%0d expected 1/4", bus.busy, bus.err_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.dut_in !== 3'd0 || bus.table_q !== 8'h00 || bus.err_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL midrun reset: busy=%b dut_in=%0d table_q=%h err_cnt=%0d expected all 0",
                  bus.busy, bus.dut_in, bus.table_q, bus.err_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0;
      start_pulse();
      monitor_run(1'b0, 8'h7F, 4'd0, 3'd0, 1'b1, "after_reset");
   endtask

   initial begin
      test_reset();
      test_nand();
      test_mismatch();
      test_random();
      test_abort();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end
endmodule
